// File: rtl/wb_regfile_scoreboard.sv
// Write-back register file with two combinational read ports, same-cycle
// write-through bypass, and a one-bit-per-register pending scoreboard that
// flags source operands whose producer has issued but not yet written back.
module wb_regfile_scoreboard #(
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_we,
  input  logic [4:0]    wb_rw,
  input  logic [DW-1:0] wb_data,
  input  logic [4:0]    rs_addr,
  input  logic [4:0]    rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  input  logic          iss_valid,
  input  logic [4:0]    iss_rd,
  input  logic          flush,
  output logic          rs_pending,
  output logic          rt_pending,
  output logic          stall
);

  logic [DW-1:0]   regs_reg [NREG];
  logic [NREG-1:0] pending_reg;
  logic [NREG-1:0] pending_next;
  logic            wb_commit;
  logic            wb_hit_rs;
  logic            wb_hit_rt;

  // r0 is never written, so it stays at its reset value of zero
  assign wb_commit = wb_we && (wb_rw != 5'd0);
  assign wb_hit_rs = wb_we && (wb_rw == rs_addr);
  assign wb_hit_rt = wb_we && (wb_rw == rt_addr);

  // Architectural register update: reset clears all, otherwise commit write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wb_commit) begin
      regs_reg[wb_rw] <= wb_data;
    end
  end

  // Scoreboard next state: a new issue wins over a same-register write-back
  always_comb begin
    pending_next = pending_reg;
    for (int i = 1; i < NREG; i++) begin
      if (iss_valid && (iss_rd == 5'(i))) begin
        pending_next[i] = 1'b1;
      end else if (wb_we && (wb_rw == 5'(i))) begin
        pending_next[i] = 1'b0;
      end
    end
    pending_next[0] = 1'b0;
  end

  // Scoreboard register: reset and flush both drop every outstanding producer
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  // Read port A: r0 is zero, then bypass from write-back, then the array
  always_comb begin
    rs_data = '0;
    if (!rst && (rs_addr != 5'd0)) begin
      rs_data = wb_hit_rs ? wb_data : regs_reg[rs_addr];
    end
  end

  // Read port B: same rules as port A
  always_comb begin
    rt_data = '0;
    if (!rst && (rt_addr != 5'd0)) begin
      rt_data = wb_hit_rt ? wb_data : regs_reg[rt_addr];
    end
  end

  // A register being written back this cycle is covered by the bypass
  always_comb begin
    rs_pending = !rst && pending_reg[rs_addr] && !wb_hit_rs;
    rt_pending = !rst && pending_reg[rt_addr] && !wb_hit_rt;
    stall      = rs_pending || rt_pending;
  end

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed and randomized bench for wb_regfile_scoreboard against an
// array-based architectural model of registers and outstanding producers.
module tb_wb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rw = '0;
  logic [31:0] wb_data = '0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic        flush = 1'b0;
  logic        rs_pending;
  logic        rt_pending;
  logic        stall;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] m_reg  [32];
  bit          m_busy [32];

  // Outputs seen in the most recent cycle, for directed constant checks
  logic [31:0] obs_rs, obs_rt;
  logic        obs_rsp, obs_rtp, obs_stall;

  wb_regfile_scoreboard #(.DW(32), .NREG(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_we      (wb_we),
    .wb_rw      (wb_rw),
    .wb_data    (wb_data),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .flush      (flush),
    .rs_pending (rs_pending),
    .rt_pending (rt_pending),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'd0;
    if (wb_we && wb_rw == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_pend(input logic [4:0] a);
    if (rst) return 1'b0;
    return m_busy[a] && !(wb_we && wb_rw == a);
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, check outputs against the model, then clock
  task automatic cyc(input logic r, input logic we, input logic [4:0] rw,
                     input logic [31:0] d, input logic [4:0] ra,
                     input logic [4:0] rb, input logic iv,
                     input logic [4:0] rd, input logic fl);
    logic ep_a, ep_b;
    rst = r; wb_we = we; wb_rw = rw; wb_data = d;
    rs_addr = ra; rt_addr = rb; iss_valid = iv; iss_rd = rd; flush = fl;
    #2;
    ep_a = exp_pend(ra);
    ep_b = exp_pend(rb);
    obs_rs = rs_data; obs_rt = rt_data;
    obs_rsp = rs_pending; obs_rtp = rt_pending; obs_stall = stall;
    chk32("rs_data", rs_data, exp_data(ra));
    chk32("rt_data", rt_data, exp_data(rb));
    chk1("rs_pending", rs_pending, ep_a);
    chk1("rt_pending", rt_pending, ep_b);
    chk1("stall", stall, ep_a || ep_b);
    $display("[TB] rst=%0b we=%0b rw=%0d d=%08h rs=%0d rt=%0d iss=%0b/%0d fl=%0b -> rs=%08h rt=%08h stall=%0b",
             r, we, rw, d, ra, rb, iv, rd, fl, rs_data, rt_data, stall);
    // Model update at the clock edge
    if (r) begin
      for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
    end else begin
      if (we && rw != 5'd0) m_reg[rw] = d;
      if (fl) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
      end else begin
        if (we) m_busy[rw] = 0;
        if (iv && rd != 5'd0) m_busy[rd] = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_reg[i] = 'x; m_busy[i] = 0; end
    @(posedge clk);
    #1;
    // Reset, then sweep every address
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) cyc(0, 0, 0, 0, 5'(2*k), 5'(2*k+1), 0, 0, 0);

    // Write with bypass, then architectural read
    cyc(0, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0);
    chk32("bypass_r5", obs_rs, 32'hDEADBEEF);
    cyc(0, 0, 0, 0, 5, 5, 0, 0, 0);
    chk32("read_r5", obs_rt, 32'hDEADBEEF);
    cyc(0, 1, 0, 32'h12345678, 0, 0, 0, 0, 0);
    chk32("r0_bypass", obs_rs, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk32("r0_read", obs_rs, 32'd0);

    // Scoreboard set and clear via write-back
    cyc(0, 0, 0, 0, 0, 0, 1, 8, 0);
    cyc(0, 0, 0, 0, 8, 0, 0, 0, 0);
    chk1("stall_r8", obs_stall, 1'b1);
    cyc(0, 1, 8, 32'h55, 8, 0, 0, 0, 0);
    chk1("wb_r8_stall", obs_stall, 1'b0);
    chk32("wb_r8_data", obs_rs, 32'h55);
    cyc(0, 0, 0, 0, 8, 0, 0, 0, 0);
    chk1("r8_cleared", obs_stall, 1'b0);

    // Simultaneous issue and write-back to r9
    cyc(0, 0, 0, 0, 0, 0, 1, 9, 0);
    cyc(0, 1, 9, 32'hA, 0, 0, 1, 9, 0);
    cyc(0, 0, 0, 0, 0, 9, 0, 0, 0);
    chk1("r9_repend", obs_rtp, 1'b1);
    chk32("r9_data", obs_rt, 32'hA);
    cyc(0, 1, 9, 32'hB, 0, 0, 0, 0, 0);

    // Flush with a concurrent write-back
    cyc(0, 0, 0, 0, 0, 0, 1, 3, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 4, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 7, 0);
    cyc(0, 1, 4, 32'h77, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 4, 3, 0, 0, 0);
    chk32("flush_r4", obs_rs, 32'h77);
    chk1("flush_stall", obs_stall, 1'b0);
    cyc(0, 0, 0, 0, 7, 7, 0, 0, 0);
    chk1("flush_r7", obs_stall, 1'b0);

    // Reset mid-operation beats a write-back
    cyc(0, 1, 10, 32'hFF, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 10, 0, 1, 10, 0);
    chk32("r10_ff", obs_rs, 32'hFF);
    cyc(1, 1, 10, 32'h1234, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 10, 10, 0, 0, 0);
    chk32("rst_r10", obs_rs, 32'd0);
    chk1("rst_r10_pend", obs_rsp, 1'b0);

    // Randomized traffic, addresses biased to a small window for collisions
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 99) == 0),
          1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)),
          $urandom,
          5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)),
          ($urandom_range(0, 29) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_regfile_scoreboard.md
Name: wb_regfile_scoreboard

Overview:
- 32x32 general-purpose register file for the pipelined MIPS core. It is the consumer end of the write-back interface: it takes write-back data, write enable and destination register, and commits them to the architectural registers.
- Two decode-stage read ports with same-cycle write-through bypass.
- A per-register pending scoreboard. Issue marks a destination register busy; write-back clears it. The block raises a stall when a source operand is still in flight.

Parameters:
- DW, 32, data width of each register
- NREG, 32, number of registers (address width fixed at 5 bits)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- wb_we  input  1  write-back enable (already gated by overflow upstream)
- wb_rw  input  5  write-back destination register
- wb_data  input  32  write-back data
- rs_addr  input  5  read port A address
- rt_addr  input  5  read port B address
- rs_data  output  32  read port A data (combinational)
- rt_data  output  32  read port B data (combinational)
- iss_valid  input  1  an instruction with a register destination issues this cycle
- iss_rd  input  5  destination register of the issuing instruction
- flush  input  1  pipeline flush; clears all pending bits
- rs_pending  output  1  rs_addr has an outstanding producer
- rt_pending  output  1  rt_addr has an outstanding producer
- stall  output  1  rs_pending OR rt_pending

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- On rst: all 32 registers become 0 and all pending bits become 0. rst has priority over every other input in the same cycle.
- Outputs during and after reset: no output is registered. rs_data/rt_data read 0, and rs_pending/rt_pending/stall are 0.
- Write:
  - If wb_we=1 and wb_rw!=0, reg[wb_rw] <= wb_data at the rising edge.
  - Writes to register 0 are discarded; reg[0] reads 0 always.
- Read:
  - rs_data = 0 if rs_addr==0.
  - Else rs_data = wb_data if wb_we && wb_rw==rs_addr (same-cycle bypass).
  - Else rs_data = reg[rs_addr].
  - rt_data follows the same rules with rt_addr.
  - Read latency 0 cycles; a write is visible architecturally from the next cycle.
- Scoreboard, pending[31:1] (pending[0] is constant 0), next-state priority per register i:
  1. rst or flush -> 0
  2. iss_valid && iss_rd==i -> 1 (a new producer wins over a simultaneous write-back to the same register)
  3. wb_we && wb_rw==i -> 0
  4. else hold
- iss_rd==0 never sets a bit.
- Pending outputs: rs_pending = pending[rs_addr] && !(wb_we && wb_rw==rs_addr). A register being written back this cycle is not reported pending because the bypass supplies its data. rt_pending uses the same rule with rt_addr.
- Write-back with no pending bit: the write still commits and the scoreboard is unchanged.
- flush does not cancel a write-back in the same cycle; the register write still commits.
- Multiple outstanding producers to one register are not tracked (1 bit per register). Issue logic must stall rather than reissue to a pending destination.

Test Plan:
- Reset: rst=1 for 1 cycle, then read all 32 addresses -> every rs_data/rt_data=0 and stall=0.
- Write/read: wb_we=1, wb_rw=5, wb_data=0xDEADBEEF -> same cycle rs_addr=5 gives 0xDEADBEEF (bypass); next cycle with wb_we=0, rs_data=0xDEADBEEF. Writing 0x12345678 to r0 -> r0 reads 0 both cycles.
- Scoreboard: iss_valid=1, iss_rd=8 -> next cycle rs_addr=8 gives stall=1. wb_we=1, wb_rw=8, wb_data=0x55 -> that cycle stall=0 and rs_data=0x55; following cycle pending cleared, stall=0.
- Simultaneous set/clear: r9 pending; in one cycle iss_valid=1, iss_rd=9 and wb_we=1, wb_rw=9, wb_data=0xA -> r9 becomes 0xA, and next cycle rt_addr=9 gives rt_pending=1.
- Flush: r3, r4 and r7 pending; flush=1 with wb_we=1, wb_rw=4, wb_data=0x77 -> next cycle no pending bits, and r4 reads 0x77.
- Reset mid-operation: r10=0xFF with r10 pending; rst=1 together with wb_we=1, wb_rw=10 -> next cycle r10 reads 0 and rs_pending for r10 is 0.
